// File: rtl/async_fifo_fwft_pkg.sv
// async_fifo_fwft_pkg: default geometry and full-threshold helper for the FWFT FIFO
package async_fifo_fwft_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_RESERVE    = 3;

    function automatic int full_threshold(input int addr_width, input int reserve);
        return (1 << addr_width) - reserve;
    endfunction
endpackage

// File: rtl/async_fifo_fwft_ram.sv
// async_fifo_fwft_ram: simple dual-port storage, synchronous write and registered read
module async_fifo_fwft_ram
    import async_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [1<<ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata_o <= '0;
        else if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/async_fifo_fwft.sv
// async_fifo_fwft: single-clock first-word-fall-through FIFO with reserve-based full flag.
// Define ASYNC_FIFO_FWFT_LEVEL_EN to expose the registered occupancy on port level.
module async_fifo_fwft
    import async_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RESERVE    = DEF_RESERVE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  has_data,
    output logic                  empty
`ifdef ASYNC_FIFO_FWFT_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);
    localparam int OW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FULL_AT = OW'(full_threshold(ADDR_WIDTH, RESERVE));

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic                  has_data_q, has_data_d, full_q, full_d;
    logic                  push, pop, load;

    // occupancy includes the output register, so RAM holds occ - has_data words
    always_comb begin
        push       = wr_en && !full_q;
        pop        = rd_en && has_data_q;
        load       = (occ_q != OW'(has_data_q)) && (!has_data_q || pop);
        wr_ptr_d   = push ? ADDR_WIDTH'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = load ? ADDR_WIDTH'(rd_ptr_q + 1'b1) : rd_ptr_q;
        occ_d      = (push && !pop) ? OW'(occ_q + 1'b1) :
                     (pop && !push) ? OW'(occ_q - 1'b1) : occ_q;
        has_data_d = load || (has_data_q && !pop);
        full_d     = occ_d >= FULL_AT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            has_data_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            has_data_q <= has_data_d;
            full_q     <= full_d;
        end
    end

    // the RAM read register doubles as the FWFT output stage
    async_fifo_fwft_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(wr_data),
        .re_i   (load),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_data)
    );

    assign has_data = has_data_q;
    assign empty    = !has_data_q;
    assign full     = full_q;
`ifdef ASYNC_FIFO_FWFT_LEVEL_EN
    assign level    = occ_q;
`endif
endmodule

// File: tb/tb_async_fifo_fwft.sv
// tb_async_fifo_fwft: randomized scoreboard bench for the FWFT FIFO at default parameters
module tb_async_fifo_fwft;
    localparam int THR = 16 - 3;

    typedef struct {
        logic [7:0] d;
        int         wc;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       full, has_data, empty;
    logic [7:0] rd_data;
`ifdef ASYNC_FIFO_FWFT_LEVEL_EN
    logic [4:0] level;
`endif

    ent_t q[$];
    logic hd_exp = 1'b0;
    logic full_exp = 1'b0;
    logic chk = 1'b0;
    int   cyc = 0;
    int   pops = 0;
    int   wr_acc = 0;
    int   tests = 0;
    int   fails = 0;

    async_fifo_fwft dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .has_data(has_data),
        .empty   (empty)
`ifdef ASYNC_FIFO_FWFT_LEVEL_EN
        ,
        .level   (level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: a word becomes visible at the head one edge after it was written.
    always @(posedge clk) begin
        if (chk) begin
            check("mon_has_data", 32'(has_data), 32'(hd_exp));
            check("mon_empty", 32'(empty), 32'(!hd_exp));
            check("mon_full", 32'(full), 32'(full_exp));
`ifdef ASYNC_FIFO_FWFT_LEVEL_EN
            check("mon_level", 32'(level), 32'(q.size()));
`endif
            if (rd_en && hd_exp && q.size() > 0) check("mon_rd_data", 32'(rd_data), 32'(q[0].d));
        end
        if (!rst_n) begin
            q.delete();
            hd_exp = 1'b0;
            full_exp = 1'b0;
            chk = 1'b1;
        end else begin
            if (rd_en && hd_exp) begin
                void'(q.pop_front());
                pops++;
            end
            if (wr_en && !full_exp) begin
                q.push_back('{wr_data, cyc});
                wr_acc++;
            end
            full_exp = q.size() >= THR;
            hd_exp = q.size() > 0 && q[0].wc < cyc;
        end
        cyc++;
    end

    task automatic drain();
        int n = 0;
        wr_en = 1'b0;
        while ((has_data || q.size() > 0) && n < 200) begin
            rd_en = has_data;
            @(negedge clk);
            n++;
        end
        rd_en = 1'b0;
        check("drain_bound", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int n, base;
        repeat (5) @(negedge clk);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_has_data", 32'(has_data), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        rst_n = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        check("single_not_yet", 32'(has_data), 32'd0);
        @(negedge clk);
        check("single_has_data", 32'(has_data), 32'd1);
        check("single_rd_data", 32'(rd_data), 32'hA5);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("single_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 14; i++) begin
            if (i == THR - 1) check("fill_not_full", 32'(full), 32'd0);
            if (i == THR) check("fill_full", 32'(full), 32'd1);
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("fill_still_full", 32'(full), 32'd1);
        pops = 0;
        drain();
        check("fill_drain_count", 32'(pops), 32'(THR));

        base = wr_acc;
        n = 0;
        while (wr_acc < base + 2000 && n < 20000) begin
            rd_en = has_data;
            wr_en = ($urandom_range(0, 1) != 0) && !full;
            wr_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check("stream_bound", 32'(n < 20000), 32'd1);
        drain();
        check("stream_final_empty", 32'(empty), 32'd1);
        check("stream_final_full", 32'(full), 32'd0);

        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        pops = 0;
        for (int i = 0; i < 40; i++) begin
            check("wrap_full", 32'(full), 32'd0);
            check("wrap_has_data", 32'(has_data), 32'd1);
            wr_en = 1'b1;
            rd_en = 1'b1;
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("wrap_pops", 32'(pops), 32'd40);
        check("wrap_end_full", 32'(full), 32'd0);
`ifdef ASYNC_FIFO_FWFT_LEVEL_EN
        check("wrap_level", 32'(level), 32'd12);
`endif
        drain();

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_has_data", 32'(has_data), 32'd0);
        check("midrst_full", 32'(full), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        pops = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        drain();
        check("midrst_pops", 32'(pops), 32'd3);
        check("midrst_final_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/async_fifo_fwft.md
ASYNC_FIFO_FWFT -- requirements
Module: async_fifo_fwft

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, log2 of storage depth (DEPTH = 2**ADDR_WIDTH = 16).
REQ-003 SHALL have parameter RESERVE, default 3, number of free slots held back before full asserts; legal range 0..DEPTH-1.
REQ-004 Ports: clk, input, 1, single clock for all logic; one clock, synchronous active-low reset.
REQ-005 Ports: rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-006 Ports: wr_en, input, 1, write request.
REQ-007 Ports: wr_data, input, DATA_WIDTH, write word.
REQ-008 Ports: full, output, 1, no further writes accepted.
REQ-009 Ports: rd_en, input, 1, consume the current head word.
REQ-010 Ports: rd_data, output, DATA_WIDTH, head word, first-word-fall-through.
REQ-011 Ports: has_data, output, 1, rd_data holds a valid word.
REQ-012 Ports: empty, output, 1, no valid word available.

Function
REQ-013 Write accepted on a rising clk edge iff wr_en=1 and full=0; wr_en while full is ignored, with no state change.
REQ-014 Read accepted on a rising clk edge iff rd_en=1 and has_data=1; rd_en while has_data=0 is ignored.
REQ-015 FWFT: head word is presented on rd_data with has_data=1 without any rd_en; rd_en pops it and presents the next word on the following cycle if one is stored.
REQ-016 Write-to-read latency: a word written into an empty FIFO at edge N appears with has_data=1 after edge N+1.
REQ-017 Data order is strictly first-in-first-out; no word is lost, duplicated or reordered.
REQ-018 occupancy counts all held words, including the output stage; range 0..DEPTH.
REQ-019 full is registered, =1 iff occupancy >= DEPTH-RESERVE (13 at defaults).
REQ-020 empty = !has_data at all times.
REQ-021 A simultaneous accepted read and write leaves occupancy unchanged; this is legal at any occupancy, including the full threshold.
REQ-022 Read/write pointers are ADDR_WIDTH bits wide and wrap modulo DEPTH silently.
REQ-023 rd_data holds its last value while has_data=0.

Reset
REQ-024 When rst_n=0 at a clk edge: pointers and occupancy go to 0, has_data=0, empty=1, full=0, rd_data=0.
REQ-025 Reset mid-operation discards all stored words; memory contents need not be cleared.
REQ-026 The first write is accepted on the first edge with rst_n=1.

Configuration
REQ-027 Macro ASYNC_FIFO_FWFT_LEVEL_EN, when defined, adds output level [ADDR_WIDTH:0] equal to the registered occupancy, reset 0.
REQ-028 Without ASYNC_FIFO_FWFT_LEVEL_EN the port is absent, and all other behaviour is identical.

Structure
REQ-029 Package async_fifo_fwft_pkg holds the default width/depth/reserve constants and a function computing the full threshold from ADDR_WIDTH and RESERVE.
REQ-030 Storage is one sub-module, async_fifo_fwft_ram: simple dual-port, DEPTH x DATA_WIDTH, synchronous write, synchronous read.
REQ-031 The top level holds the pointers, occupancy, flags and FWFT output register.

Verification
REQ-032 Reset sequence: hold rst_n=0 for 5 cycles -> empty=1, has_data=0, full=0, rd_data=0.
REQ-033 Single word: write 0xA5 into empty FIFO at edge N -> has_data=1 and rd_data=0xA5 after edge N+1 with rd_en=0; rd_en=1 for one cycle -> empty=1.
REQ-034 Fill without reads (defaults): full asserts after the 13th accepted write; a 14th wr_en is ignored; draining yields exactly the 13 words in order.
REQ-035 Streaming: rd_en=has_data and wr_en=random&~full for 2000 random writes, checked by a scoreboard queue -> every read matches, no underflow, and the final occupancy is 0.
REQ-036 Wrap and simultaneity: keep occupancy at 12 with simultaneous read+write for 40 cycles -> occupancy stays 12, data stays ordered across pointer wrap, and full stays 0.
REQ-037 Reset mid-stream: assert rst_n=0 with 8 words stored -> the next cycle shows empty=1; after release, new writes read back correctly with no stale words.
